// File: rtl/alu_multiword_sequencer.sv
// Multi-word add/subtract sequencer driving a shared WIDTH-bit ALU slice.
// Ports: clk/rst; start/op/a/b request; busy/done/err status; result and
// wide C/Z/N/V flags; alu_a/alu_b/alu_cin/alu_control to the slice,
// alu_result/alu_carry back from it.
module alu_multiword_sequencer #(
  parameter int WIDTH = 4,
  parameter int WORDS = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [3:0]             op,
  input  logic [WORDS*WIDTH-1:0] a,
  input  logic [WORDS*WIDTH-1:0] b,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic [WORDS*WIDTH-1:0] result,
  output logic                   flag_c,
  output logic                   flag_z,
  output logic                   flag_n,
  output logic                   flag_v,
  output logic [WIDTH-1:0]       alu_a,
  output logic [WIDTH-1:0]       alu_b,
  output logic                   alu_cin,
  output logic [3:0]             alu_control,
  input  logic [WIDTH-1:0]       alu_result,
  input  logic                   alu_carry
);

  localparam int N  = WORDS * WIDTH;
  localparam int CW = $clog2(WORDS);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [3:0] OP_ADD = 4'b1000;
  localparam logic [3:0] OP_SUB = 4'b1001;
  localparam logic [3:0] OP_NOP = 4'b0000;

  localparam logic [CW-1:0] LAST = CW'(WORDS - 1);

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [N-1:0]     a_q;
  logic [N-1:0]     b_q;
  logic [3:0]       op_q;
  logic             carry_q;

  logic             legal;
  logic [WIDTH-1:0] a_word;
  logic [WIDTH-1:0] b_word;
  logic [N-1:0]     res_next;
  logic             a_msb;
  logic             beff_msb;
  logic             r_msb;
  logic             v_next;

  assign legal = (op == OP_ADD) || (op == OP_SUB);

  // Current word slices and the result with the in-flight word merged in,
  // so Z can be taken from the full value on the final edge.
  always_comb begin
    a_word   = a_q[int'(cnt)*WIDTH +: WIDTH];
    b_word   = b_q[int'(cnt)*WIDTH +: WIDTH];
    res_next = result;
    res_next[int'(cnt)*WIDTH +: WIDTH] = alu_result;
  end

  // Overflow uses the effective B operand (inverted for subtract).
  assign a_msb    = a_word[WIDTH-1];
  assign beff_msb = (op_q == OP_SUB) ? ~b_word[WIDTH-1] : b_word[WIDTH-1];
  assign r_msb    = alu_result[WIDTH-1];
  assign v_next   = (a_msb ^ r_msb) & ~(a_msb ^ beff_msb);

  assign busy = (state == S_RUN);
  assign done = (state == S_DONE);

  // The slice sees a quiet no-carry op outside RUN.
  assign alu_a       = busy ? a_word  : '0;
  assign alu_b       = busy ? b_word  : '0;
  assign alu_cin     = busy ? carry_q : 1'b0;
  assign alu_control = busy ? op_q    : OP_NOP;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= OP_NOP;
      carry_q <= 1'b0;
      err     <= 1'b0;
      result  <= '0;
      flag_c  <= 1'b0;
      flag_z  <= 1'b0;
      flag_n  <= 1'b0;
      flag_v  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            if (legal) begin
              a_q     <= a;
              b_q     <= b;
              op_q    <= op;
              cnt     <= '0;
              carry_q <= (op == OP_SUB);
              err     <= 1'b0;
              state   <= S_RUN;
            end else begin
              err   <= 1'b1;
              state <= S_DONE;
            end
          end
        end
        S_RUN: begin
          result  <= res_next;
          carry_q <= alu_carry;
          if (cnt == LAST) begin
            flag_c <= alu_carry;
            flag_v <= v_next;
            flag_n <= r_msb;
            flag_z <= (res_next == '0);
            state  <= S_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DONE: begin
          err   <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_multiword_sequencer.sv
// Scoreboard bench for alu_multiword_sequencer with a behavioural ALU slice.
// Expected results are queued on start and compared on done.
module tb_alu_multiword_sequencer;

  localparam int W  = 4;
  localparam int WD = 4;
  localparam int N  = W * WD;

  localparam logic [3:0] ADD = 4'b1000;
  localparam logic [3:0] SUB = 4'b1001;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [3:0]   op;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         busy;
  logic         done;
  logic         err;
  logic [N-1:0] result;
  logic         flag_c;
  logic         flag_z;
  logic         flag_n;
  logic         flag_v;
  logic [W-1:0] alu_a;
  logic [W-1:0] alu_b;
  logic         alu_cin;
  logic [3:0]   alu_control;
  logic [W-1:0] alu_result;
  logic         alu_carry;

  typedef struct packed {
    logic [N-1:0] r;
    logic c;
    logic z;
    logic n;
    logic v;
    logic e;
  } exp_t;

  exp_t q[$];
  exp_t prev;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  alu_multiword_sequencer #(.WIDTH(W), .WORDS(WD)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .err(err), .result(result),
    .flag_c(flag_c), .flag_z(flag_z), .flag_n(flag_n), .flag_v(flag_v),
    .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin),
    .alu_control(alu_control), .alu_result(alu_result),
    .alu_carry(alu_carry)
  );

  always_comb begin
    logic [W:0] s;
    s = '0;
    case (alu_control)
      ADD: s = {1'b0, alu_a} + {1'b0, alu_b} + {{W{1'b0}}, alu_cin};
      SUB: s = {1'b0, alu_a} + {1'b0, ~alu_b} + {{W{1'b0}}, alu_cin};
      default: s = '0;
    endcase
    alu_result = s[W-1:0];
    alu_carry  = s[W];
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [3:0] o,
                                 input logic [N-1:0] x,
                                 input logic [N-1:0] y);
    exp_t e;
    logic [N:0] s;
    logic [N-1:0] be;
    if (o != ADD && o != SUB) begin
      e = prev;
      e.e = 1'b1;
      return e;
    end
    be  = (o == SUB) ? ~y : y;
    s   = {1'b0, x} + {1'b0, be} + {{N{1'b0}}, (o == SUB)};
    e.r = s[N-1:0];
    e.c = s[N];
    e.z = (s[N-1:0] == '0);
    e.n = s[N-1];
    e.v = (x[N-1] ^ s[N-1]) & ~(x[N-1] ^ be[N-1]);
    e.e = 1'b0;
    return e;
  endfunction

  function automatic logic cin_exp(input logic [3:0] o,
                                   input logic [N-1:0] x,
                                   input logic [N-1:0] y,
                                   input int i);
    logic [N:0]   s;
    logic [N-1:0] m;
    logic [N-1:0] be;
    m  = (i == 0) ? '0 : ({N{1'b1}} >> (N - i * W));
    be = (o == SUB) ? ~y : y;
    s  = {1'b0, x & m} + {1'b0, be & m} + {{N{1'b0}}, (o == SUB)};
    return s[i*W];
  endfunction

  task automatic run_op(input logic [3:0] o, input logic [N-1:0] x,
                        input logic [N-1:0] y, input bit poke);
    exp_t e;
    exp_t got;
    int   n;
    int   lat;
    bit   lg;
    lg = (o == ADD) || (o == SUB);
    e  = model(o, x, y);
    q.push_back(e);
    if (lg) prev = e;
    lat   = lg ? WD + 1 : 1;
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = N'($urandom);
    b     = N'($urandom);
    op    = 4'($urandom);
    n = 1;
    while (!done && n < 20) begin
      chk("busy", 32'(busy), 32'(lg));
      chk("alu_a", 32'(alu_a), 32'(x[(n-1)*W +: W]));
      chk("alu_b", 32'(alu_b), 32'(y[(n-1)*W +: W]));
      chk("alu_cin", 32'(alu_cin), 32'(cin_exp(o, x, y, n - 1)));
      chk("alu_ctl", 32'(alu_control), 32'(o));
      start = poke && (n == 2);
      if (start) op = ADD;
      @(posedge clk);
      #1;
      n++;
    end
    start = 1'b0;
    chk("latency", n, lat);
    if (q.size() > 0) begin
      got = q.pop_front();
      chk("result", 32'(result), 32'(got.r));
      chk("flag_c", 32'(flag_c), 32'(got.c));
      chk("flag_z", 32'(flag_z), 32'(got.z));
      chk("flag_n", 32'(flag_n), 32'(got.n));
      chk("flag_v", 32'(flag_v), 32'(got.v));
      chk("err", 32'(err), 32'(got.e));
    end else begin
      chk("sb_empty", 32'(q.size()), 32'd1);
    end
    @(posedge clk);
    #1;
    chk("done_pulse", 32'(done), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("err_clr", 32'(err), 32'd0);
  endtask

  initial begin
    prev  = '0;
    rst   = 1'b1;
    start = 1'b0;
    op    = '0;
    a     = '0;
    b     = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_flags", 32'({flag_c, flag_z, flag_n, flag_v}), 32'd0);
    chk("rst_ctl", 32'(alu_control), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    run_op(ADD, 16'h00FF, 16'h0001, 1'b0);
    run_op(ADD, 16'hFFFF, 16'h0001, 1'b0);
    run_op(SUB, 16'h8000, 16'h0001, 1'b0);
    run_op(SUB, 16'h0003, 16'h0005, 1'b1);
    run_op(4'b0000, 16'h1111, 16'h2222, 1'b0);
    run_op(ADD, 16'h7FFF, 16'h0001, 1'b0);
    run_op(4'b1010, 16'h0000, 16'h0000, 1'b0);

    // Reset mid-run while word 2 is on the slice.
    start = 1'b1;
    op    = ADD;
    a     = 16'h0F0F;
    b     = 16'h0101;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("pre_rst_busy", 32'(busy), 32'd1);
    chk("pre_rst_cin", 32'(alu_cin), 32'(cin_exp(ADD, 16'h0F0F, 16'h0101, 2)));
    #2;
    rst = 1'b1;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_result", 32'(result), 32'd0);
    chk("arst_flags", 32'({flag_c, flag_z, flag_n, flag_v}), 32'd0);
    prev = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    run_op(ADD, 16'h1234, 16'h1111, 1'b0);
    for (int k = 0; k < 6; k++) begin
      run_op(k[0] ? SUB : ADD, N'($urandom), N'($urandom), 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
